// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - masked fixed-priority interrupt controller with irq/iack/EOI handshake (option: IRQ_CTRL_LEVEL_EN)
module irq_controller #(
  parameter int N_SRC       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq,
  input  logic             iack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_CAUSE   = 2'd2;
  localparam logic [1:0] ADDR_EOI     = 2'd3;

  state_t           state, state_nx;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] masked;
  logic [N_SRC-1:0] win_oh;
  logic [2:0]       win_idx;
  logic             any_req;
  logic             cause_valid;
  logic [2:0]       cause_idx;
  logic             wr_en, wr_pend, wr_mask, wr_eoi;
  logic             take_iack;
  logic             unused_wdata;

  assign wr_en   = sel & we;
  assign wr_pend = wr_en && (addr == ADDR_PENDING);
  assign wr_mask = wr_en && (addr == ADDR_MASK);
  assign wr_eoi  = wr_en && (addr == ADDR_EOI);

  assign masked  = pending & mask;
  assign any_req = |masked;

  // iack only counts in REQ while something is still requesting
  assign take_iack = (state == REQ) && iack && any_req;

  // Upper write-data bits have no storage behind them
  assign unused_wdata = ^wdata[31:N_SRC];

  // Synchronizer chain for the asynchronous source lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= src;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef IRQ_CTRL_LEVEL_EN
  logic unused_level;
  assign unused_level = wr_pend ^ (^win_oh);

  // Level mode: PENDING simply mirrors the synchronized lines
  assign pending = sync_q[SYNC_STAGES-1];
`else
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;

  // Delayed copy of the synchronized lines for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= '0;
    else      prev_q <= sync_q[SYNC_STAGES-1];
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Clear sources: software W1C plus the acknowledged winner
  always_comb begin
    clr = '0;
    if (wr_pend)   clr = clr | wdata[N_SRC-1:0];
    if (take_iack) clr = clr | win_oh;
  end

  // Pending latch; a same-cycle edge overrides any clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= (pending & ~clr) | rise;
  end
`endif

  // Fixed priority: lowest enabled pending index wins
  always_comb begin
    win_idx = '0;
    win_oh  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (masked[i]) begin
        win_idx   = 3'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  // MASK register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         mask <= '0;
    else if (wr_mask) mask <= wdata[N_SRC-1:0];
  end

  // CAUSE: captured on acknowledge, valid dropped by EOI in service
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cause_valid <= 1'b0;
      cause_idx   <= '0;
    end else if (take_iack) begin
      cause_valid <= 1'b1;
      cause_idx   <= win_idx;
    end else if (state == SVC && wr_eoi) begin
      cause_valid <= 1'b0;
    end
  end

  // Handshake state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Handshake next-state: request, acknowledge, wait for EOI
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = REQ;
      REQ: begin
        if (!any_req)  state_nx = IDLE;
        else if (iack) state_nx = SVC;
      end
      SVC:     if (wr_eoi) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // irq comes straight from the state flop, so it is glitch-free
  assign irq = (state == REQ);

  // Read mux; unimplemented bits and EOI read as zero
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        ADDR_PENDING: rdata[N_SRC-1:0] = pending;
        ADDR_MASK:    rdata[N_SRC-1:0] = mask;
        ADDR_CAUSE:   rdata = {cause_valid, 28'b0, cause_idx};
        ADDR_EOI:     rdata = '0;
        default:      rdata = '0;
      endcase
    end
  end

endmodule
